// File: rtl/ifetch_stage.sv
// MIPS32 instruction-fetch stage: PC register, next-PC selection, IF/ID pipeline register
// and a retired-fetch counter.
module ifetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFID_Write,
  input  logic        Jump,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCplus4,
  output logic        IF_ID_Valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] pcPlus4Reg;
  logic        validReg;
  logic [31:0] countReg;

  logic [31:0] pcPlus4;
  logic [31:0] jumpTarget;
  logic [31:0] branchAddr;
  logic [31:0] pcNext;
  logic        redirect;

  assign pcPlus4    = pcReg + 32'd4;
  assign jumpTarget = {pcPlus4Reg[31:28], instrReg[25:0], 2'b00};
  assign branchAddr = {branch_target[31:2], 2'b00};
  assign redirect   = branch_taken | Jump;

  // Branch resolves in MEM, so it is older than a J sitting in IF/ID and wins.
  always_comb begin
    pcNext = pcReg;
    if (branch_taken) begin
      pcNext = branchAddr;
    end else if (Jump) begin
      pcNext = jumpTarget;
    end else if (PCWrite) begin
      pcNext = pcPlus4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcReg      <= PC_RESET;
      instrReg   <= NOP_INSTR;
      pcPlus4Reg <= 32'd0;
      validReg   <= 1'b0;
      countReg   <= 32'd0;
    end else begin
      pcReg <= pcNext;
      // A redirect squashes the fetch in flight even when the hazard unit is stalling.
      if (redirect) begin
        instrReg   <= NOP_INSTR;
        pcPlus4Reg <= 32'd0;
        validReg   <= 1'b0;
      end else if (IFID_Write) begin
        instrReg   <= imem_data;
        pcPlus4Reg <= pcPlus4;
        validReg   <= 1'b1;
        countReg   <= countReg + 32'd1;
      end
    end
  end

  assign imem_addr     = pcReg;
  assign pc            = pcReg;
  assign IF_ID_Instr   = instrReg;
  assign IF_ID_PCplus4 = pcPlus4Reg;
  assign IF_ID_Valid   = validReg;
  assign fetch_count   = countReg;

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the 5-stage MIPS32 pipeline. Holds the PC, selects the next PC (sequential, jump, taken branch), drives the instruction-memory address, and owns the IF/ID pipeline register consumed by ID-stage decode, main control and the hazard unit. Honours the hazard unit's PCWrite/IFID_Write stall controls and flushes IF/ID on control-flow redirects. Keeps a retired-fetch counter for performance checks.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush (sll $0,$0,0)

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- PCWrite  in  1  hazard unit: 1 = PC may advance sequentially
- IFID_Write  in  1  hazard unit: 1 = IF/ID may load
- Jump  in  1  main control (ID stage): instruction in IF/ID is J
- branch_taken  in  1  branch resolved taken (MEM stage)
- branch_target  in  32  byte address of taken branch
- imem_addr  out  32  byte address to instruction memory (= pc)
- imem_data  in  32  instruction word, combinational read of imem_addr
- pc  out  32  current PC register
- IF_ID_Instr  out  32  registered instruction
- IF_ID_PCplus4  out  32  registered PC+4 of that instruction
- IF_ID_Valid  out  1  1 = IF/ID holds a real fetched instruction
- fetch_count  out  32  number of instructions accepted into IF/ID since reset

## Operation
- pc_plus4 = pc + 4, 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- jump_target = {IF_ID_PCplus4[31:28], IF_ID_Instr[25:0], 2'b00}.
- Effective branch target = {branch_target[31:2], 2'b00}; low bits ignored.
- Next-PC priority (highest first): reset -> PC_RESET; branch_taken -> branch target; Jump -> jump_target; PCWrite=1 -> pc_plus4; else hold.
- Redirects (branch_taken or Jump) override PCWrite=0.
- IF/ID priority: reset -> {NOP_INSTR, 0, Valid=0}; branch_taken or Jump -> flush: {NOP_INSTR, 0, Valid=0}; IFID_Write=1 -> {imem_data, pc_plus4, Valid=1}; else hold all three fields.
- Flush overrides IFID_Write=0 (hazard unit drives IFID_Write=0 during Branched; this block still inserts NOP).
- Jump with Jump asserted while IF_ID_Valid=0 is a protocol error; block still obeys the priority above (no special case).
- fetch_count increments by 1 on every edge where IF/ID loads with Valid=1; cleared by reset; wraps at 2^32.
- No FSM beyond the registers; state = pc, IF/ID fields, fetch_count.

## Timing
- Reset values: pc = PC_RESET, imem_addr = PC_RESET, IF_ID_Instr = NOP_INSTR, IF_ID_PCplus4 = 0, IF_ID_Valid = 0, fetch_count = 0.
- First cycle after reset deasserts: imem_addr = PC_RESET; one edge later IF_ID_Instr = mem[PC_RESET], IF_ID_Valid = 1.
- Fetch latency: 1 cycle from imem_addr to IF/ID.
- imem_addr is purely combinational from pc (no extra register).
- Jump penalty: 1 bubble (instruction fetched behind J is flushed). Branch penalty: the instruction in IF is flushed on the taken edge; earlier younger instructions are flushed by downstream stages, not here.
- Load-use stall (PCWrite=0, IFID_Write=0, no redirect): pc and IF/ID hold exactly; fetch_count holds.
- Reset asserted mid-stall or mid-redirect: reset wins on that edge.
- Simultaneous branch_taken and Jump: branch_taken wins (older instruction).

## Test plan
- Reset then 4 free-running cycles, imem[i]=i+1: IF_ID_Instr sequence 1,2,3,4; IF_ID_PCplus4 4,8,12,16; fetch_count=4; pc=16.
- PCWrite=0, IFID_Write=0 for 2 cycles at pc=8: pc stays 8, IF/ID unchanged, fetch_count unchanged; release -> resumes at 8.
- J with target field 26'h40 at PC 0x1000_0010: next pc = 0x1000_0100, next IF_ID_Valid=0, IF_ID_Instr=NOP_INSTR.
- branch_taken=1, branch_target=32'h0000_0203 with PCWrite=0, IFID_Write=0: pc=0x200, IF/ID flushed, fetch_count unchanged.
- branch_taken and Jump same cycle: pc = branch target, not jump target.
- pc=32'hFFFF_FFFC free run: pc wraps to 0, IF_ID_PCplus4 = 0; reset asserted during stall -> pc=PC_RESET, all outputs at reset values.
